// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 control unit.
// Holds state codes, opcodes, mux selects, ALU codes and the imm decoder.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Immediate format depends only on the opcode, never on state.
  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    logic [1:0] s;
    s = IMM_I;
    unique case (1'b1)
      op == OP_SW:  s = IMM_S;
      op == OP_BEQ: s = IMM_B;
      op == OP_JAL: s = IMM_J;
      default:      s = IMM_I;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decoder.
// In: alu_op, funct3, op5, funct7b5. Out: alu_control.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    unique case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FN: begin
        unique case (funct3)
          // addi has no funct7, so only R-type may subtract
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32 subset core.
// In: clk, rst, opcode, funct3, funct7b5, zero. Out: datapath/memory controls, illegal, dbg_state.
module multicycle_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W      = 4,
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         imm_src,
  output logic [2:0]         alu_control,
  output logic               illegal,
  output logic [STATE_W-1:0] dbg_state
);

  state_t     state;
  state_t     state_n;
  state_t     cur;
  logic       illegal_q;
  logic [1:0] alu_op;
  logic       upd;
  logic       br;
  logic       ir_w;
  logic       reg_w;
  logic       mem_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n == HALT) illegal_q <= 1'b1;
    end
  end

  // Reset presents FETCH decoding; enables are gated separately below.
  assign cur = rst ? FETCH : state;

  always_comb begin
    state_n    = FETCH;
    adr_src    = 1'b0;
    mem_w      = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    upd        = 1'b0;
    br         = 1'b0;
    unique case (cur)
      FETCH: begin
        ir_w       = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        upd        = 1'b1;
        state_n    = DECODE;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        unique case (1'b1)
          opcode == OP_LW,
          opcode == OP_SW:  state_n = MEMADR;
          opcode == OP_R:   state_n = EXECR;
          opcode == OP_I:   state_n = EXECI;
          opcode == OP_BEQ: state_n = BEQ;
          opcode == OP_JAL: state_n = JAL;
          default: state_n = ILLEGAL_TRAP ? HALT : FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        state_n   = opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        state_n = MEMWB;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      EXECR: begin
        alu_src_a = SRCA_REG;
        alu_op    = ALUOP_FN;
        state_n   = ALUWB;
      end
      EXECI: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FN;
        state_n   = ALUWB;
      end
      ALUWB: reg_w = 1'b1;
      BEQ: begin
        alu_src_a = SRCA_REG;
        alu_op    = ALUOP_SUB;
        br        = 1'b1;
      end
      JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        upd       = 1'b1;
        state_n   = ALUWB;
      end
      HALT:    state_n = HALT;
      default: state_n = FETCH;
    endcase
  end

  assign pc_write  = ~rst & (upd | (br & zero));
  assign ir_write  = ~rst & ir_w;
  assign reg_write = ~rst & reg_w;
  assign mem_write = ~rst & mem_w;
  assign imm_src   = imm_sel(opcode);
  assign illegal   = illegal_q;
  assign dbg_state = STATE_W'(cur);

  alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (opcode[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control unit of the multi-cycle RV32 subset core: lw, sw, R-type, I-type ALU, beq, jal.
- Sits directly upstream of the unified instruction/data memory and the datapath.
- Drives the memory address-source select and write enable, the IR/PC/register-file enables, ALU operand selects and the ALU control code.
- Moore-style state register plus a combinational ALU decoder.

Parameters:
STATE_W, 4, width of the dbg_state output. Must be >= 4.
ILLEGAL_TRAP, 0, 0: an unknown opcode in DECODE returns to FETCH. 1: it enters HALT and asserts illegal.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
opcode  input  7  instr[6:0] from the instruction register
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag
pc_write  output  1  PC register enable
adr_src  output  1  memory address select: 0=PC, 1=ALUOut
mem_write  output  1  memory write enable
ir_write  output  1  IR/OldPC enable
reg_write  output  1  register-file write enable
result_src  output  2  00=ALUOut, 01=mem Data reg, 10=ALUResult
alu_src_a  output  2  00=PC, 01=OldPC, 10=A reg
alu_src_b  output  2  00=B reg, 01=ImmExt, 10=constant 4
imm_src  output  2  00=I, 01=S, 10=B, 11=J
alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
illegal  output  1  sticky illegal-opcode flag
dbg_state  output  STATE_W  current state encoding, zero-extended

Behaviour:
Clock and reset:
- One clock (clk).
- rst is synchronous and active-high.
- rst=1 at a posedge: state<=FETCH, illegal<=0.
- While rst=1, pc_write, ir_write, reg_write and mem_write are forced 0. All other outputs take their FETCH values.
- Reset asserted mid-instruction aborts it. No memory or register write occurs in the reset cycle.

State encoding and outputs (unlisted outputs are 0):
- FETCH(0): adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, result_src=10, pc_update=1. Next: DECODE.
- DECODE(1): alu_src_a=01, alu_src_b=01 (branch target). Next by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other opcode -> FETCH (ILLEGAL_TRAP=0) or HALT (ILLEGAL_TRAP=1)
- MEMADR(2): alu_src_a=10, alu_src_b=01. Next: MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD(3): adr_src=1, result_src=00. Next: MEMWB.
- MEMWB(4): result_src=01, reg_write=1. Next: FETCH.
- MEMWRITE(5): adr_src=1, result_src=00, mem_write=1. Next: FETCH.
- EXECR(6): alu_src_a=10, alu_src_b=00, alu_op=10. Next: ALUWB.
- EXECI(7): alu_src_a=10, alu_src_b=01, alu_op=10. Next: ALUWB.
- ALUWB(8): result_src=00, reg_write=1. Next: FETCH.
- BEQ(9): alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1. Next: FETCH.
- JAL(10): alu_src_a=01, alu_src_b=10, result_src=00, pc_update=1. Next: ALUWB.
- HALT(11): all enables 0. Stays in HALT until rst. illegal=1.
- Unused encodings 12-15 go to FETCH on the next edge.

Derived signals:
- pc_write = pc_update | (branch & zero).
- imm_src is decoded from opcode alone: lw/I-type=00, sw=01, beq=10, jal=11, others=00.

ALU decoder:
- alu_op=00 -> add.
- alu_op=01 -> sub.
- alu_op=10, by funct3:
  - 000 -> sub if (opcode[5] & funct7b5), else add
  - 010 -> slt
  - 110 -> or
  - 111 -> and
  - others -> add

Cycles per instruction (FETCH entry to next FETCH entry): lw 5, sw 4, R 4, I 4, beq 3, jal 4.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state localparams FETCH..HALT
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL
  - select encodings for result_src, alu_src_a, alu_src_b, imm_src
  - ALU code constants
- Sub-module alu_decoder: combinational; inputs alu_op, funct3, opcode[5], funct7b5; output alu_control.

Test Plan:
- Reset: hold rst=1 for 2 cycles with opcode=0100011 -> mem_write=0, pc_write=0, ir_write=0, dbg_state=0. Release -> first edge moves to DECODE.
- lw (opcode 0000011): states 0,1,2,3,4,0. adr_src=1 in MEMREAD. reg_write=1 with result_src=01 only in MEMWB. mem_write never 1.
- sw (opcode 0100011): states 0,1,2,5,0. mem_write=1 for exactly one cycle with adr_src=1. imm_src=01.
- R-type sub (0110011, funct3=000, funct7b5=1): alu_control=001 in EXECR. reg_write=1 in ALUWB only. Same input with opcode 0010011 -> alu_control=000.
- beq: zero=1 -> pc_write=1 in state 9. zero=0 -> pc_write=0. Both cases return to FETCH after 3 cycles.
- Illegal opcode 1111111: with ILLEGAL_TRAP=1 -> HALT (11), illegal=1, held 10 cycles with no enables asserted, cleared by rst. With ILLEGAL_TRAP=0 -> returns to FETCH, illegal stays 0.
